load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit and the data memory.
// The master side issues requests; the slave answers with ready/rdata.
`ifndef XLEN
`define XLEN 32
`endif

interface load_store_unit_if #(
    parameter int XLEN = `XLEN
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligns stores onto byte lanes, issues one
// bus transfer per access and sign/zero-extends the returned load data.
`ifndef XLEN
`define XLEN 32
`endif

module load_store_unit #(
    parameter int XLEN = `XLEN
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                op_valid,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     store_data,
    input  logic                flush,
    load_store_unit_if.master   bus,
    output logic                mem_stall,
    output logic                load_done,
    output logic [XLEN-1:0]     load_data,
    output logic                ex_load_misaligned,
    output logic                ex_store_misaligned
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state;
    logic            discard;
    logic            ld_we;
    logic            ld_uns;
    logic [1:0]      ld_size;
    logic [OW-1:0]   ld_off;

    logic            access;
    logic            misaligned;
    logic            accept;
    logic            in_idle;
    logic [NB-1:0]   strb_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ext;

    always_comb begin
        access = op_valid & (mem_read | mem_write) & ~flush;
        unique case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = (XLEN == 32) | (|addr[2:0]);
        endcase
        in_idle             = reset_n & (state == IDLE);
        accept              = in_idle & access & ~misaligned;
        ex_load_misaligned  = in_idle & access & misaligned & mem_read;
        ex_store_misaligned = in_idle & access & misaligned & ~mem_read;
        mem_stall           = reset_n & (accept | (state == REQ));
        load_done           = reset_n & (state == RESP) & ~flush;
    end

    // Byte enables cover the access size starting at the byte offset;
    // write data repeats the low bytes so every lane carries its byte.
    always_comb begin
        int sz_b;
        int off_i;
        sz_b    = 1 << funct3[1:0];
        off_i   = int'(addr[OW-1:0]);
        strb_n  = '0;
        wdata_n = '0;
        for (int i = 0; i < NB; i++) begin
            strb_n[i] = (i >= off_i) && (i < off_i + sz_b);
            wdata_n[8*i +: 8] = store_data[8*(i % sz_b) +: 8];
        end
    end

    always_comb begin
        int bits;
        bits = 8 << ld_size;
        if (bits > XLEN) bits = XLEN;
        lane = bus.mem_rdata >> {ld_off, 3'b000};
        ext  = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < bits) ext[i] = lane[i];
            else          ext[i] = ~ld_uns & lane[bits-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            discard       <= 1'b0;
            ld_we         <= 1'b0;
            ld_uns        <= 1'b0;
            ld_size       <= '0;
            ld_off        <= '0;
            load_data     <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= REQ;
                        discard       <= 1'b0;
                        ld_we         <= mem_write & ~mem_read;
                        ld_uns        <= funct3[2];
                        ld_size       <= funct3[1:0];
                        ld_off        <= addr[OW-1:0];
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= mem_write & ~mem_read;
                        bus.mem_addr  <= {addr[XLEN-1:OW], {OW{1'b0}}};
                        bus.mem_wdata <= wdata_n;
                        bus.mem_wstrb <= strb_n;
                    end
                end
                REQ: begin
                    if (flush) discard <= 1'b1;
                    // A flushed transfer still runs to completion on the bus.
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        load_data   <= ld_we ? '0 : ext;
                        state       <= (discard | flush) ? IDLE : RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
